// File: rtl/sd_spi_byte_engine.sv
// sd_spi_byte_engine
// Byte-level SPI master, mode 0, MSB first. One execute pulse exchanges one
// byte: out_word is shifted out on mosi while a byte is shifted in from miso.
// spi_clk is generated internally at one of two rates chosen at start time.
module sd_spi_byte_engine #(
  parameter int SLOW_HALF = 63,  // spi_clk half-period (clk cycles), init rate
  parameter int FAST_HALF = 2    // spi_clk half-period (clk cycles), data rate
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       execute,
  input  logic       fast_mode,
  input  logic [7:0] out_word,
  input  logic       miso,
  output logic       spi_clk,
  output logic       mosi,
  output logic [7:0] in_word,
  output logic       finished,
  output logic       busy
);

  localparam int MAX_HALF = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
  // A half-period of 1 would give $clog2 = 0; keep the counter at least 1 bit.
  localparam int DIV_W    = (MAX_HALF > 1) ? $clog2(MAX_HALF) : 1;

  localparam logic [DIV_W-1:0] SLOW_LAST = DIV_W'(SLOW_HALF - 1);
  localparam logic [DIV_W-1:0] FAST_LAST = DIV_W'(FAST_HALF - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,  // spi_clk low phase
    HIGH = 2'd2   // spi_clk high phase
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] half_last;  // H-1 for the transfer in flight
  logic [2:0]       bit_cnt;
  logic [6:0]       tx_shift;   // bits still to be presented on mosi
  logic [7:0]       rx_shift;

  // Transfer sequencer: divider, bit counter, shift registers and all outputs.
  // NOTE: every register here is updated with <= so all of them see the
  // pre-edge values of each other; a blocking '=' would chain updates.
  // NOTE: the block holds only small control/shift registers, so all of them
  // are reset; a reset mid-byte therefore discards any partial data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      div_cnt   <= '0;
      half_last <= '0;
      bit_cnt   <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      spi_clk   <= 1'b0;
      mosi      <= 1'b1;
      in_word   <= 8'h00;
      finished  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      finished <= 1'b0;
      case (state)
        IDLE: begin
          spi_clk <= 1'b0;
          if (execute && !busy) begin
            tx_shift  <= out_word[6:0];
            mosi      <= out_word[7];
            bit_cnt   <= '0;
            div_cnt   <= '0;
            half_last <= fast_mode ? FAST_LAST : SLOW_LAST;
            busy      <= 1'b1;
            state     <= LOW;
          end else begin
            mosi <= 1'b1;
          end
        end

        LOW: begin
          if (div_cnt == half_last) begin
            div_cnt  <= '0;
            spi_clk  <= 1'b1;
            // Rising-edge sample of the card's data.
            rx_shift <= {rx_shift[6:0], miso};
            state    <= HIGH;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        HIGH: begin
          if (div_cnt == half_last) begin
            div_cnt <= '0;
            spi_clk <= 1'b0;
            if (bit_cnt != 3'd7) begin
              bit_cnt  <= bit_cnt + 1'b1;
              // Next bit changes on the falling edge, a half-period ahead of
              // the card's rising-edge sample.
              mosi     <= tx_shift[6];
              tx_shift <= {tx_shift[5:0], 1'b0};
              state    <= LOW;
            end else begin
              in_word  <= rx_shift;
              finished <= 1'b1;
              busy     <= 1'b0;
              mosi     <= 1'b1;
              state    <= IDLE;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_spi_byte_engine.sv
// Directed testbench for sd_spi_byte_engine. A cycle-by-cycle monitor plays
// the card: it feeds miso MSB first (changing after spi_clk falls), collects
// mosi at every spi_clk rise and checks edge timing, busy and finished.
module tb_sd_spi_byte_engine;

  localparam int SH = 63;
  localparam int FH = 2;

  logic       clk;
  logic       rst_n;
  logic       execute;
  logic       fast_mode;
  logic [7:0] out_word;
  logic       miso;
  logic       spi_clk;
  logic       mosi;
  logic [7:0] in_word;
  logic       finished;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  sd_spi_byte_engine #(
    .SLOW_HALF(SH),
    .FAST_HALF(FH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .execute  (execute),
    .fast_mode(fast_mode),
    .out_word (out_word),
    .miso     (miso),
    .spi_clk  (spi_clk),
    .mosi     (mosi),
    .in_word  (in_word),
    .finished (finished),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a start request; returns #1 after the accepting edge t0.
  task automatic start(input logic [7:0] tx, input logic [7:0] rx, input logic fm);
    out_word  = tx;
    fast_mode = fm;
    miso      = rx[7];
    execute   = 1'b1;
    @(posedge clk);
    #1;
    execute  = 1'b0;
    out_word = ~tx;  // later changes must not matter
  endtask

  // Follow one transfer from t0 to t0+16H and check everything about it.
  // poke: cycle at which a stray execute (out_word=0) is pulsed, 0 = none.
  // fm_at: cycle at which fast_mode is forced to 1, 0 = none.
  task automatic monitor(input logic [7:0] tx, input logic [7:0] rx, input int h,
                         input int poke, input int fm_at, input string tag,
                         output int fin_cyc);
    logic [7:0] got_tx;
    int rises, falls, bad_rise, busy_cnt, early_fin;
    logic prev;
    got_tx    = 8'h00;
    rises     = 0;
    falls     = 0;
    bad_rise  = 0;
    early_fin = 0;
    prev      = spi_clk;
    busy_cnt  = (busy === 1'b1) ? 1 : 0;
    for (int cyc = 1; cyc <= 16 * h; cyc++) begin
      @(posedge clk);
      #1;
      if (spi_clk === 1'b1 && prev === 1'b0) begin
        if (cyc != h * (2 * rises + 1)) bad_rise++;
        got_tx = {got_tx[6:0], mosi};
        rises++;
      end
      if (spi_clk === 1'b0 && prev === 1'b1) begin
        falls++;
        if (falls < 8) miso = rx[7 - falls];
      end
      prev = spi_clk;
      if (cyc < 16 * h) begin
        if (busy === 1'b1) busy_cnt++;
        if (finished !== 1'b0) early_fin++;
      end
      if (poke != 0 && cyc == poke) begin
        out_word = 8'h00;
        execute  = 1'b1;
      end
      if (poke != 0 && cyc == poke + 1) execute = 1'b0;
      if (fm_at != 0 && cyc == fm_at) fast_mode = 1'b1;
    end
    fin_cyc = cycle;
    check({tag, " finished at 16H"}, finished, 1'b1);
    check({tag, " busy low at 16H"}, busy, 1'b0);
    check({tag, " mosi idle high"}, mosi, 1'b1);
    check({tag, " in_word"}, in_word, rx);
    check({tag, " mosi bits"}, got_tx, tx);
    check({tag, " rise count"}, rises, 8);
    check({tag, " rise timing errs"}, bad_rise, 0);
    check({tag, " busy cycles"}, busy_cnt, 16 * h);
    check({tag, " early finished"}, early_fin, 0);
  endtask

  initial begin
    int bad;
    int fin_a, fin_b;
    int rises;
    logic prev;

    rst_n     = 1'b0;
    execute   = 1'b0;
    fast_mode = 1'b0;
    out_word  = 8'h00;
    miso      = 1'b1;

    // Reset values while held in reset.
    #23;
    check("rst spi_clk", spi_clk, 1'b0);
    check("rst mosi", mosi, 1'b1);
    check("rst in_word", in_word, 8'h00);
    check("rst busy", busy, 1'b0);
    check("rst finished", finished, 1'b0);

    // Release and idle for 200 cycles: nothing may move.
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (spi_clk !== 1'b0 || mosi !== 1'b1 || busy !== 1'b0 ||
          finished !== 1'b0 || in_word !== 8'h00) bad++;
    end
    check("idle outputs stable", bad, 0);

    // Slow byte: 0x40 out, 0xA5 in, 1008 cycles.
    start(8'h40, 8'hA5, 1'b0);
    monitor(8'h40, 8'hA5, SH, 0, 0, "slow", fin_a);

    // Fast back-to-back: execute presented in the finished cycle.
    @(posedge clk);
    #1;
    start(8'hFF, 8'h01, 1'b1);
    monitor(8'hFF, 8'h01, FH, 0, 0, "fast1", fin_a);
    start(8'h95, 8'hFE, 1'b1);
    monitor(8'h95, 8'hFE, FH, 0, 0, "fast2", fin_b);
    check("b2b finished spacing", fin_b - fin_a, 33);

    // Execute while busy is ignored.
    @(posedge clk);
    #1;
    start(8'h3C, 8'hC3, 1'b1);
    monitor(8'h3C, 8'hC3, FH, 10, 0, "busy_exec", fin_a);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (busy !== 1'b0 || spi_clk !== 1'b0 || finished !== 1'b0) bad++;
    end
    check("no second transfer", bad, 0);

    // Reset mid-transfer after the 4th rising edge, in_word previously 0x5A.
    start(8'h11, 8'h5A, 1'b1);
    monitor(8'h11, 8'h5A, FH, 0, 0, "pre_rst", fin_a);
    @(posedge clk);
    #1;
    start(8'hC7, 8'h33, 1'b0);
    rises = 0;
    prev  = spi_clk;
    for (int i = 0; i < 2000 && rises < 4; i++) begin
      @(posedge clk);
      #1;
      if (spi_clk === 1'b1 && prev === 1'b0) rises++;
      prev = spi_clk;
    end
    check("reached 4th rise", rises, 4);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst spi_clk", spi_clk, 1'b0);
    check("midrst mosi", mosi, 1'b1);
    check("midrst in_word", in_word, 8'h00);
    check("midrst busy", busy, 1'b0);
    check("midrst finished", finished, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 1100; i++) begin
      @(posedge clk);
      #1;
      if (finished !== 1'b0 || busy !== 1'b0 || in_word !== 8'h00) bad++;
    end
    check("no finish after abort", bad, 0);
    start(8'h69, 8'h96, 1'b1);
    monitor(8'h69, 8'h96, FH, 0, 0, "post_rst", fin_a);

    // Rate latch: fast_mode toggled at cycle 100 of a slow transfer.
    @(posedge clk);
    #1;
    start(8'hB2, 8'h4D, 1'b0);
    monitor(8'hB2, 8'h4D, SH, 0, 100, "latch_slow", fin_a);
    @(posedge clk);
    #1;
    start(8'h2B, 8'hD4, 1'b1);
    monitor(8'h2B, 8'hD4, FH, 0, 0, "latch_fast", fin_a);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
